// File: rtl/kf6845_pkg.sv
// Shared types and constants for the KF6845 CRTC register blocks.
// The light pen glitch filter (KF6845_LPEN_GLITCH_FILTER_EN) uses LPEN_FILTER_COUNT.
package kf6845_pkg;

  typedef logic [13:0] ma_t;

  typedef enum logic [0:0] {
    LPEN_ARMED = 1'b0,
    LPEN_HELD  = 1'b1
  } lpen_state_t;

  localparam int unsigned LPEN_FILTER_COUNT = 3;
  localparam int unsigned BUS_W             = 8;
  localparam logic [BUS_W-1:0] BUS_IDLE_DATA = 8'hFF;

endpackage

// File: rtl/kf6845_light_pen_if.sv
// Bus-control side of the light pen register: read strobes, read data and capture flag.
interface kf6845_light_pen_if;

  logic [7:0] internal_data_bus_out;
  logic       read_light_pen_h_register;
  logic       read_light_pen_l_register;
  logic       light_pen_flag;

  modport master (
    output read_light_pen_h_register,
    output read_light_pen_l_register,
    input  internal_data_bus_out,
    input  light_pen_flag
  );

  modport slave (
    input  read_light_pen_h_register,
    input  read_light_pen_l_register,
    output internal_data_bus_out,
    output light_pen_flag
  );

endinterface

// File: rtl/kf6845_sync_edge.sv
// LPSTB synchronizer and rising-edge detector producing a one-clock pulse.
// With KF6845_LPEN_GLITCH_FILTER_EN the synchronized level must hold for 4 clocks first.
module kf6845_sync_edge
  import kf6845_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic i_strobe,
  output logic o_rise_c
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_level;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_strobe};
    end
  end

`ifdef KF6845_LPEN_GLITCH_FILTER_EN
  logic [1:0] r_count;

  // Saturating run-length counter; any low sample restarts qualification.
  always_ff @(posedge clock) begin
    if (reset || !r_sync[SYNC_STAGES-1]) begin
      r_count <= 2'd0;
    end else if (r_count != 2'(LPEN_FILTER_COUNT)) begin
      r_count <= r_count + 2'd1;
    end
  end

  assign w_level = r_sync[SYNC_STAGES-1] & (r_count == 2'(LPEN_FILTER_COUNT));
`else
  assign w_level = r_sync[SYNC_STAGES-1];
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= w_level;
    end
  end

  assign o_rise_c = w_level & ~r_prev;

endmodule

// File: rtl/kf6845_light_pen.sv
// KF6845 light pen capture: latches MA (+MA_ADJUST) on a strobe edge into R16/R17.
// Optional build macro: KF6845_LPEN_GLITCH_FILTER_EN (strobe glitch filter).
module kf6845_light_pen
  import kf6845_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter ma_t         MA_ADJUST   = 14'd0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                video_clock_enable,
  input  logic                LPSTB,
  input  ma_t                 MA,
  kf6845_light_pen_if.slave   bus
);

  localparam logic [0:0] ST_ARMED = 1'(LPEN_ARMED);
  localparam logic [0:0] ST_HELD  = 1'(LPEN_HELD);

  logic [0:0]  r_state;
  logic        r_pending;
  logic        r_flag;
  ma_t         r_address;

  logic [0:0]  w_state_nx;
  logic        w_pending_nx;
  logic        w_flag_nx;
  ma_t         w_address_nx;
  logic        w_rise;
  logic [7:0]  w_bus_data_c;

  kf6845_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clock    (clock),
    .reset    (reset),
    .i_strobe (LPSTB),
    .o_rise_c (w_rise)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_ARMED;
      r_pending <= 1'b0;
      r_flag    <= 1'b0;
      r_address <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_pending <= w_pending_nx;
      r_flag    <= w_flag_nx;
      r_address <= w_address_nx;
    end
  end

  // A fresh edge coinciding with an enable captures immediately; otherwise it waits as pending.
  always_comb begin
    w_state_nx   = r_state;
    w_pending_nx = r_pending;
    w_flag_nx    = r_flag;
    w_address_nx = r_address;
    case (r_state)
      ST_ARMED: begin
        if ((r_pending | w_rise) & video_clock_enable) begin
          w_address_nx = MA + MA_ADJUST;
          w_flag_nx    = 1'b1;
          w_pending_nx = 1'b0;
          w_state_nx   = ST_HELD;
        end else if (w_rise) begin
          w_pending_nx = 1'b1;
        end
      end
      ST_HELD: begin
        if (bus.read_light_pen_l_register) begin
          w_flag_nx  = 1'b0;
          w_state_nx = ST_ARMED;
        end
      end
    endcase
  end

  // Read mux: H wins when both strobes are asserted.
  always_comb begin
    w_bus_data_c = BUS_IDLE_DATA;
    if (bus.read_light_pen_h_register) begin
      w_bus_data_c = {2'b00, r_address[13:8]};
    end else if (bus.read_light_pen_l_register) begin
      w_bus_data_c = r_address[7:0];
    end
  end

  assign bus.internal_data_bus_out = w_bus_data_c;
  assign bus.light_pen_flag        = r_flag;

endmodule

// File: tb/tb_kf6845_light_pen.sv
// Directed bench for kf6845_light_pen; dut0 uses MA_ADJUST=0, dut1 MA_ADJUST=2.
// Expectations follow KF6845_LPEN_GLITCH_FILTER_EN when it is defined.
module tb_kf6845_light_pen;
  import kf6845_pkg::*;

  localparam int unsigned SYNC = 2;
`ifdef KF6845_LPEN_GLITCH_FILTER_EN
  localparam int unsigned CAP_BUDGET     = SYNC + 5 + 3;
  localparam logic        SHORT_CAPTURES = 1'b0;
`else
  localparam int unsigned CAP_BUDGET     = SYNC + 5;
  localparam logic        SHORT_CAPTURES = 1'b1;
`endif

  logic clock;
  logic reset;
  logic vce;
  logic lpstb;
  ma_t  ma;

  int n_cmp;
  int n_err;
  int cyc;
  bit vce_auto;
  int lp_left;
  bit lp_hold;

  kf6845_light_pen_if bus0 ();
  kf6845_light_pen_if bus1 ();

  kf6845_light_pen #(.SYNC_STAGES(SYNC), .MA_ADJUST(14'd0)) dut0 (
    .clock              (clock),
    .reset              (reset),
    .video_clock_enable (vce),
    .LPSTB              (lpstb),
    .MA                 (ma),
    .bus                (bus0)
  );

  kf6845_light_pen #(.SYNC_STAGES(SYNC), .MA_ADJUST(14'd2)) dut1 (
    .clock              (clock),
    .reset              (reset),
    .video_clock_enable (vce),
    .LPSTB              (lpstb),
    .MA                 (ma),
    .bus                (bus1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock; inputs change on the falling edge, strobes default low.
  task automatic step();
    @(negedge clock);
    cyc++;
    if (vce_auto) vce = (cyc % 4 == 0);
    lpstb = lp_hold || (lp_left > 0);
    if (lp_left > 0) lp_left--;
    bus0.read_light_pen_h_register = 1'b0;
    bus0.read_light_pen_l_register = 1'b0;
    bus1.read_light_pen_h_register = 1'b0;
    bus1.read_light_pen_l_register = 1'b0;
  endtask

  task automatic rd(input bit h, input bit l);
    bus0.read_light_pen_h_register = h;
    bus0.read_light_pen_l_register = l;
    bus1.read_light_pen_h_register = h;
    bus1.read_light_pen_l_register = l;
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_flag(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < int'(CAP_BUDGET) && !seen; i++) begin
      step();
      #1;
      seen = bus0.light_pen_flag;
    end
    check(tag, 8'(seen), 8'h01);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0;
    reset = 1'b1; vce = 1'b0; lpstb = 1'b0; ma = '0;
    vce_auto = 1'b1; lp_left = 0; lp_hold = 1'b0;
    bus0.read_light_pen_h_register = 1'b0;
    bus0.read_light_pen_l_register = 1'b0;
    bus1.read_light_pen_h_register = 1'b0;
    bus1.read_light_pen_l_register = 1'b0;

    // Reset state
    repeat (3) step();
    reset = 1'b0;
    step(); #1;
    check("rst_flag", 8'(bus0.light_pen_flag), 8'h00);
    rd(1, 0); check("rst_read_h", bus0.internal_data_bus_out, 8'h00);
    step(); rd(0, 1); check("rst_read_l", bus0.internal_data_bus_out, 8'h00);
    step(); #1; check("idle_bus", bus0.internal_data_bus_out, 8'hFF);
    rd(1, 1); check("both_h_prio", bus0.internal_data_bus_out, 8'h00);

    // Basic capture of 0x1234
    ma = 14'h1234;
    lp_left = 6;
    wait_flag("cap1_flag");
    step(); rd(1, 0); check("cap1_read_h", bus0.internal_data_bus_out, 8'h12);
    check("cap1_adj_read_h", bus1.internal_data_bus_out, 8'h12);
    repeat (6) step();

    // Strobes while HELD are ignored
    ma = 14'h0F0F;
    repeat (3) begin
      lp_left = 3;
      repeat (7) step();
    end
    repeat (12) step(); #1;
    check("held_flag", 8'(bus0.light_pen_flag), 8'h01);
    rd(1, 0); check("held_read_h", bus0.internal_data_bus_out, 8'h12);
    step(); rd(0, 1); check("held_read_l", bus0.internal_data_bus_out, 8'h34);
    check("held_adj_read_l", bus1.internal_data_bus_out, 8'h36);
    step(); #1; check("release_flag", 8'(bus0.light_pen_flag), 8'h00);

    // Next pulse after release captures the new MA
    lp_left = 6;
    wait_flag("cap2_flag");
    step(); rd(1, 0); check("cap2_read_h", bus0.internal_data_bus_out, 8'h0F);
    step(); rd(0, 1); check("cap2_read_l", bus0.internal_data_bus_out, 8'h0F);
    repeat (8) step();

    // MA_ADJUST wraps modulo 2^14
    ma = 14'h3FFF;
    lp_left = 6;
    wait_flag("cap3_flag");
    step(); rd(1, 0);
    check("wrap_read_h", bus1.internal_data_bus_out, 8'h00);
    check("noadj_read_h", bus0.internal_data_bus_out, 8'h3F);
    step(); rd(0, 1);
    check("wrap_read_l", bus1.internal_data_bus_out, 8'h01);
    check("noadj_read_l", bus0.internal_data_bus_out, 8'hFF);
    repeat (8) step();

    // Capture coincides with read_l; then a held-high strobe captures only once
    vce_auto = 1'b0; vce = 1'b0;
    ma = 14'h0555;
    lp_hold = 1'b1;
    repeat (10) step(); #1;
    check("pend_no_cap_flag", 8'(bus0.light_pen_flag), 8'h00);
    step(); vce = 1'b1; rd(0, 1);
    check("coinc_old_low", bus0.internal_data_bus_out, 8'hFF);
    step(); vce = 1'b0; #1;
    check("coinc_flag", 8'(bus0.light_pen_flag), 8'h01);
    rd(1, 0); check("coinc_read_h", bus0.internal_data_bus_out, 8'h05);
    step(); #1; check("read_h_keeps_flag", 8'(bus0.light_pen_flag), 8'h01);
    rd(0, 1); check("coinc_read_l", bus0.internal_data_bus_out, 8'h55);
    step(); #1; check("coinc_release", 8'(bus0.light_pen_flag), 8'h00);
    vce = 1'b1;
    repeat (8) step(); #1;
    check("hold_high_once", 8'(bus0.light_pen_flag), 8'h00);
    lp_hold = 1'b0; vce = 1'b0;
    repeat (4) step();

    // Reset while a capture is pending
    lp_left = 6;
    repeat (10) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step(); vce = 1'b1;
    repeat (6) step(); #1;
    check("rst_pend_flag", 8'(bus0.light_pen_flag), 8'h00);
    rd(1, 0); check("rst_pend_read_h", bus0.internal_data_bus_out, 8'h00);
    step(); rd(0, 1); check("rst_pend_read_l", bus0.internal_data_bus_out, 8'h00);

    // Two-clock pulse: captures only without the glitch filter
    vce_auto = 1'b1;
    ma = 14'h0222;
    lp_left = 2;
    repeat (12) step(); #1;
    check("short_flag", 8'(bus0.light_pen_flag), 8'(SHORT_CAPTURES));
    rd(0, 1);
    check("short_read_l", bus0.internal_data_bus_out, SHORT_CAPTURES ? 8'h22 : 8'h00);
    step(); #1; check("short_release", 8'(bus0.light_pen_flag), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
